booth_radix4_seq_multiplier: RTL and testbench

Sequential radix-4 Booth multiplier. It is the parametrised successor of the single-slice Booth partial-product generator. One operand pair is accepted per transaction over a valid/ready handshake. The block retires one Booth digit per clock, accumulating the selected multiple (0, ±B, ±2B) into a shift-right accumulator. It supports signed and unsigned operands at any even width and feeds PE/accumulator stages in the array datapath.

---
 rtl/booth_radix4_seq_multiplier.sv | 124 ++++++++++++
 tb/tb_booth_radix4_seq_multiplier.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_multiplier.sv
// Sequential radix-4 Booth multiplier: one operand pair per valid/ready transaction,
// one Booth digit retired per clock into a shift-right accumulator.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// BUSY  | retiring one Booth digit per clock
// DONE  | product presented, held until out_ready

module booth_radix4_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy
);
    localparam int DIGITS = WIDTH / 2 + 1;
    localparam int MW     = 2 * DIGITS + 1;
    localparam int BW     = WIDTH + 2;
    localparam int AW     = 2 * WIDTH + 4;
    localparam int CW     = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   mplier;
    logic [BW-1:0]   mcand;
    logic [BW-1:0]   mcand_neg;
    logic [AW-1:0]   acc;

    logic            ext_a;
    logic            ext_b;
    logic [BW-1:0]   b_ext;
    logic [BW-1:0]   multiple;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   acc_next;

    assign ext_a = in_signed & in_a[WIDTH-1];
    assign ext_b = in_signed & in_b[WIDTH-1];
    assign b_ext = {ext_b, ext_b, in_b};

    // 2B never wraps in BW bits: |B| < 2^WIDTH after extension.
    always_comb begin
        multiple = '0;
        case (mplier[2:0])
            3'b001, 3'b010: multiple = mcand;
            3'b011:         multiple = {mcand[BW-2:0], 1'b0};
            3'b100:         multiple = {mcand_neg[BW-2:0], 1'b0};
            3'b101, 3'b110: multiple = mcand_neg;
            default:        multiple = '0;
        endcase
    end

    // Multiple lands in the top BW bits so that after DIGITS shifts the exact product
    // sits at bit 0; the running sum always fits AW signed bits, so modular add is safe.
    always_comb begin
        acc_sum  = {acc[AW-1 -: BW] + multiple, acc[AW-BW-1:0]};
        acc_next = AW'($signed(acc_sum) >>> 2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_product <= '0;
            cnt         <= '0;
            acc         <= '0;
            mplier      <= '0;
            mcand       <= '0;
            mcand_neg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mplier    <= {ext_a, ext_a, in_a, 1'b0};
                        mcand     <= b_ext;
                        mcand_neg <= '0 - b_ext;
                        acc       <= '0;
                        cnt       <= CW'(DIGITS - 1);
                        state     <= BUSY;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 2;
                    if (cnt == '0) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        out_valid   <= 1'b1;
                        out_product <= acc_next[2*WIDTH-1:0];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// Bench for booth_radix4_seq_multiplier: directed WIDTH=8 cases plus randomized
// regression at WIDTH 4/8/16 against a plain-arithmetic product and timing model.

module tb_booth_radix4_seq_multiplier;
    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_go  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    function automatic longint unsigned ref_mul(input int w, input bit sgn,
                                                input longint unsigned a,
                                                input longint unsigned b);
        longint m, sa, sb;
        m  = (longint'(1) << w) - 1;
        sa = longint'(a) & m;
        sb = longint'(b) & m;
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        return longint'(sa * sb) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Directed instance, WIDTH=8
    logic        d_rst_n, d_iv, d_ir, d_sg, d_ov, d_ordy, d_bz;
    logic [7:0]  d_a, d_b;
    logic [15:0] d_p;

    booth_radix4_seq_multiplier #(.WIDTH(8)) dut_d (
        .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_ready(d_ir),
        .in_signed(d_sg), .in_a(d_a), .in_b(d_b), .out_valid(d_ov),
        .out_ready(d_ordy), .out_product(d_p), .busy(d_bz)
    );

    task automatic d_start(input bit sg, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] e, input string nm);
        int lat, bc;
        check({nm, "_model"}, ref_mul(8, sg, a, b), e);
        d_sg = sg; d_a = a; d_b = b; d_iv = 1'b1; d_ordy = 1'b0;
        check({nm, "_in_ready"}, d_ir, 1);
        @(negedge clk);
        d_iv = 1'b0;
        lat = 0;
        bc  = 0;
        while (!d_ov && lat < 20) begin
            if (d_bz) bc++;
            d_a = 8'($urandom); d_b = 8'($urandom); d_sg = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, 5);
        check({nm, "_busy_cycles"}, bc, 5);
        check({nm, "_product"}, d_p, e);
        check({nm, "_in_ready_done"}, d_ir, 0);
    endtask

    task automatic d_drain(input string nm);
        d_ordy = 1'b1;
        @(negedge clk);
        d_ordy = 1'b0;
        check({nm, "_drain_valid"}, d_ov, 0);
        check({nm, "_drain_ready"}, d_ir, 1);
    endtask

    // Randomized instances
    logic r_rst_n;

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int W = (g == 0) ? 4 : (g == 1) ? 8 : 16;
        localparam int D = W / 2 + 1;
        localparam int N = 3334;

        logic           iv, ir, sg, ov, ordy, bz;
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p;
        bit             done;

        booth_radix4_seq_multiplier #(.WIDTH(W)) dut (
            .clk(clk), .rst_n(r_rst_n), .in_valid(iv), .in_ready(ir),
            .in_signed(sg), .in_a(a), .in_b(b), .out_valid(ov),
            .out_ready(ordy), .out_product(p), .busy(bz)
        );

        initial begin : drv
            bit pend, sat, drain;
            int left, ops, cyc, last_acc;
            longint unsigned mp;
            pend = 0; sat = 0; drain = 0; left = 0; ops = 0; cyc = 0; last_acc = -1; mp = 0;
            iv = 1'b0; ordy = 1'b0; a = '0; b = '0; sg = 1'b0; done = 0;
            wait (rand_go);
            @(negedge clk);
            while (cyc < 60000 && !(drain && !pend)) begin
                sat   = (ops >= N);
                drain = (ops >= N + 12);
                iv    = drain ? 1'b0 : (sat ? 1'b1 : ($urandom_range(3) != 0));
                ordy  = sat ? 1'b1 : ($urandom_range(3) != 0);
                a     = W'($urandom);
                b     = W'($urandom);
                sg    = 1'($urandom);
                if (ir && iv) begin
                    if (sat && last_acc >= 0)
                        check($sformatf("w%0d_throughput", W), cyc - last_acc, D + 2);
                    last_acc = sat ? cyc : -1;
                end
                @(posedge clk);
                cyc++;
                // Reference timing: accept, DIGITS digit edges, then hold until taken.
                if (!pend) begin
                    if (iv) begin
                        pend = 1;
                        left = D;
                        mp   = ref_mul(W, sg, a, b);
                        ops++;
                    end
                end else if (left > 0) begin
                    left--;
                end else if (ordy) begin
                    pend = 0;
                end
                @(negedge clk);
                check($sformatf("w%0d_in_ready", W), ir, !pend);
                check($sformatf("w%0d_busy", W), bz, pend && left > 0);
                check($sformatf("w%0d_out_valid", W), ov, pend && left == 0);
                if (pend && left == 0)
                    check($sformatf("w%0d_product", W), p, mp);
            end
            check($sformatf("w%0d_no_timeout", W), cyc < 60000, 1);
            done = 1;
        end
    end

    initial begin : main
        int t;
        d_rst_n = 1'b0; r_rst_n = 1'b0;
        d_iv = 1'b0; d_ordy = 1'b0; d_sg = 1'b0; d_a = '0; d_b = '0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", d_ir, 1);
        check("reset_out_valid", d_ov, 0);
        check("reset_busy", d_bz, 0);
        check("reset_product", d_p, 0);
        d_rst_n = 1'b1; r_rst_n = 1'b1;
        @(negedge clk);

        d_start(1'b1, 8'h80, 8'h80, 16'h4000, "s_m128_m128"); d_drain("s_m128_m128");
        d_start(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff");     d_drain("u_ff_ff");
        d_start(1'b1, 8'hFF, 8'hFF, 16'h0001, "s_m1_m1");     d_drain("s_m1_m1");
        d_start(1'b1, 8'hFF, 8'h7F, 16'hFF81, "s_m1_7f");     d_drain("s_m1_7f");
        d_start(1'b0, 8'h00, 8'hFF, 16'h0000, "u_00_ff");     d_drain("u_00_ff");

        d_start(1'b0, 8'h12, 8'h34, 16'h03A8, "stall");
        for (int i = 0; i < 10; i++) begin
            d_iv = 1'b1; d_a = 8'($urandom); d_b = 8'($urandom); d_sg = 1'($urandom);
            @(negedge clk);
            d_iv = 1'b0;
            check("stall_product", d_p, 16'h03A8);
            check("stall_out_valid", d_ov, 1);
            check("stall_in_ready", d_ir, 0);
        end
        d_drain("stall");
        @(negedge clk);
        check("stall_not_accepted", d_bz, 0);

        d_sg = 1'b0; d_a = 8'h21; d_b = 8'h43; d_iv = 1'b1;
        @(negedge clk);
        d_iv = 1'b0;
        repeat (3) @(negedge clk);
        d_rst_n = 1'b0;
        #1;
        check("midrst_in_ready", d_ir, 1);
        check("midrst_out_valid", d_ov, 0);
        check("midrst_busy", d_bz, 0);
        check("midrst_product", d_p, 0);
        @(negedge clk);
        d_rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (d_ov) t++;
        end
        check("midrst_no_late_valid", t, 0);
        d_start(1'b0, 8'h03, 8'h05, 16'h000F, "after_rst"); d_drain("after_rst");

        rand_go = 1;
        t = 0;
        while (!(g_rand[0].done && g_rand[1].done && g_rand[2].done) && t < 70000) begin
            @(negedge clk);
            t++;
        end
        check("rand_all_done", {g_rand[2].done, g_rand[1].done, g_rand[0].done}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
